list_walker: RTL and testbench
==============================

Name: list_walker

Overview:
- Traverses a cons list in `memory` through its read port (`req`/`addr_in`/`data_ready`/`data_out`).
- Streams each car word to a downstream consumer over a valid/ready handshake.
- Sits between the eval/control sequencer and `memory`; consumes the cell pointers that `memory`'s `cons_ptr` output produces.
- Terminates on NIL; flags improper lists and over-length (cyclic) lists.

Parameters:
- ADDR_W, 12, memory word address width.
- DATA_W, 16, memory word / pointer width.
- MAX_LEN, 1024, maximum cells walked before aborting with error.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a walk when idle.
- head_ptr  in  DATA_W  list pointer, sampled on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of walk.
- error  out  1  valid with done: 1 = improper tail or MAX_LEN exceeded.
- count  out  16  number of cars emitted; valid with done, held until next start.
- req  out  1  memory read request.
- addr_in  out  ADDR_W  memory read address.
- data_ready  in  1  memory read data valid.
- data_out  in  DATA_W  memory read data.
- car_valid  out  1  emitted car word valid.
- car_data  out  DATA_W  emitted car word.
- car_ready  in  1  downstream accepts car word.

Behaviour:
- Pointer format:
  - [15:12] is the tag, [11:0] is the address.
  - 16'h0000 = NIL.
  - Tag 4'h1 = cons pointer.
  - Any other value = atom.
- Cell layout: car at address A, cdr at A+1, mod 2^ADDR_W; address 12'hFFF wraps the cdr fetch to 12'h000.
- Reset values: busy, done, error, req, car_valid = 0; addr_in, car_data, count = 0; state = IDLE.
- States:
  - IDLE
    - start with head NIL -> DONE: count=0, error=0.
    - start with tag 1 -> FETCH_CAR.
    - start with any other value -> DONE with error=1.
    - start while busy is ignored.
  - FETCH_CAR
    - req=1, addr_in=cur[11:0], held stable until a cycle with data_ready=1.
    - data_out captured into car_data that cycle; req=0 next cycle.
    - -> EMIT.
  - EMIT
    - car_valid=1, car_data stable until car_ready=1; transfer on the valid&&ready cycle.
    - On transfer, count++; -> FETCH_CDR.
  - FETCH_CDR
    - req=1, addr_in=cur[11:0]+1; same handshake as FETCH_CAR.
    - Captured cdr NIL -> DONE, error=0.
    - Tag 1 -> cur=cdr, -> FETCH_CAR.
    - Otherwise -> DONE, error=1 (improper list).
  - Length limit: a cdr arriving when count==MAX_LEN and cdr≠NIL -> DONE, error=1.
  - DONE: done=1 for exactly one cycle, busy=0 that same cycle, -> IDLE.
- Timing rules:
  - req is never asserted in the cycle following a data_ready capture: a minimum one idle cycle between requests.
  - data_ready while req=0 is ignored.
  - Minimum per-cell latency with single-cycle memory and car_ready tied high: 6 cycles (request, capture, gap, emit, request, capture).
- error and count hold their values after done until the next accepted start; both clear on accepted start.
- rst mid-walk: all state returns to reset values next cycle.
  - No done pulse.
  - An outstanding memory response arriving after reset is ignored.
- start coincident with rst: rst wins.

Test Plan:
- Empty list: start, head_ptr=16'h0000 -> done 1 cycle later, count=0, error=0, req never asserted.
- Three-cell list (memory preloaded 0x010:DEAD/1012, 0x012:1234/1014, 0x014:ABCD/0000), start head=16'h1010, car_ready=1 -> car stream DEAD, 1234, ABCD; reads at 010,011,012,013,014,015 in order; count=3, error=0.
- Backpressure: same list, car_ready low for 5 cycles on each car -> car_data stable while car_valid && !car_ready; no req during stall; identical stream and count=3.
- Improper tail: cell 0x020 = 0042/7005 -> emits 0042, then done with error=1, count=1.
- Cycle: cell 0x030 = 0001/1030, MAX_LEN=4 -> exactly 4 cars emitted, then done with error=1, count=4.
- Reset mid-walk: assert rst during FETCH_CDR with data_ready one cycle later -> all outputs 0, no done, stray data_ready ignored; a new start then walks correctly.

Source files
------------

// File: rtl/list_walker.sv
// Walks a cons list in memory, streaming each car word downstream over valid/ready.
// Ends on NIL; flags improper tails and lists longer than MAX_LEN.
module list_walker #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MAX_LEN = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] head_ptr,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       count,
  output logic              req,
  output logic [ADDR_W-1:0] addr_in,
  input  logic              data_ready,
  input  logic [DATA_W-1:0] data_out,
  output logic              car_valid,
  output logic [DATA_W-1:0] car_data,
  input  logic              car_ready
);

  localparam int unsigned   TagW    = DATA_W - ADDR_W;
  localparam logic [TagW-1:0] ConsTag = TagW'(1);
  localparam logic [15:0]   MaxLen  = 16'(MAX_LEN);

  typedef enum logic [2:0] {
    StIdle, StFetchCar, StEmit, StFetchCdr, StGap, StDone
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cur_q, cur_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   car_q, car_d;
  logic [15:0]         count_q, count_d;
  logic                error_q, error_d;

  function automatic logic is_cons(logic [DATA_W-1:0] p);
    return p[DATA_W-1:ADDR_W] == ConsTag;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cur_q   <= '0;
      addr_q  <= '0;
      car_q   <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      addr_q  <= addr_d;
      car_q   <= car_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    addr_d  = addr_q;
    car_d   = car_q;
    count_d = count_q;
    error_d = error_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          count_d = '0;
          error_d = 1'b0;
          if (head_ptr == '0) begin
            state_d = StDone;
          end else if (is_cons(head_ptr)) begin
            cur_d   = head_ptr[ADDR_W-1:0];
            addr_d  = head_ptr[ADDR_W-1:0];
            state_d = StFetchCar;
          end else begin
            error_d = 1'b1;
            state_d = StDone;
          end
        end
      end
      StFetchCar: begin
        if (data_ready) begin
          car_d   = data_out;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (car_ready) begin
          count_d = count_q + 16'd1;
          addr_d  = cur_q + ADDR_W'(1);
          state_d = StFetchCdr;
        end
      end
      StFetchCdr: begin
        if (data_ready) begin
          if (data_out == '0) begin
            state_d = StDone;
          end else if (count_q == MaxLen || !is_cons(data_out)) begin
            error_d = 1'b1;
            state_d = StDone;
          end else begin
            cur_d   = data_out[ADDR_W-1:0];
            addr_d  = data_out[ADDR_W-1:0];
            state_d = StGap;
          end
        end
      end
      // Keeps req low for one cycle after a cdr capture.
      StGap:   state_d = StFetchCar;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign req       = (state_q == StFetchCar) || (state_q == StFetchCdr);
  assign car_valid = (state_q == StEmit);
  assign done      = (state_q == StDone);
  assign busy      = (state_q != StIdle) && (state_q != StDone);
  assign addr_in   = addr_q;
  assign car_data  = car_q;
  assign count     = count_q;
  assign error     = error_q;

endmodule

// File: tb/tb_list_walker.sv
// Directed bench for list_walker: bench-side memory responder, car/read logs, scenario tasks.
module tb_list_walker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] head_ptr = '0;
  logic        busy, done, error;
  logic [15:0] count;
  logic        req;
  logic [11:0] addr_in;
  logic        data_ready = 1'b0;
  logic [15:0] data_out = '0;
  logic        car_valid;
  logic [15:0] car_data;
  logic        car_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] mem [0:4095];
  logic [15:0] cars [$];
  logic [11:0] reads [$];
  int          done_cnt = 0;
  int          req_cnt = 0;

  list_walker #(.ADDR_W(12), .DATA_W(16), .MAX_LEN(4)) dut (
    .clk(clk), .rst(rst), .start(start), .head_ptr(head_ptr),
    .busy(busy), .done(done), .error(error), .count(count),
    .req(req), .addr_in(addr_in), .data_ready(data_ready), .data_out(data_out),
    .car_valid(car_valid), .car_data(car_data), .car_ready(car_ready)
  );

  always #5 clk = ~clk;

  // Single-cycle memory: answers one cycle after req, then drops for a cycle.
  always @(posedge clk) begin
    data_ready <= req && !data_ready;
    data_out   <= mem[addr_in];
  end

  always @(posedge clk) begin
    if (req === 1'b1 && data_ready === 1'b1) reads.push_back(addr_in);
    if (car_valid === 1'b1 && car_ready === 1'b1) cars.push_back(car_data);
    if (done === 1'b1) done_cnt++;
    if (req === 1'b1) req_cnt++;
  end

  task automatic start_walk(input logic [15:0] h);
    @(negedge clk);
    head_ptr = h;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done, error, req, car_valid} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags got=%b want=00000", {busy, done, error, req, car_valid});
    end
    n_vec++;
    if (addr_in !== 12'h000) begin
      n_err++;
      $display("FAIL reset_addr got=%h want=000", addr_in);
    end
    n_vec++;
    if (car_data !== 16'h0000 || count !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_data car_data=%h count=%0d want 0/0", car_data, count);
    end
    rst = 1'b0;
  endtask

  task automatic test_empty();
    req_cnt = 0;
    start_walk(16'h0000);
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL empty_done done=%b busy=%b want 1/0", done, busy);
    end
    n_vec++;
    if (count !== 16'd0 || error !== 1'b0) begin
      n_err++;
      $display("FAIL empty_result count=%0d error=%b want 0/0", count, error);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || req_cnt !== 0) begin
      n_err++;
      $display("FAIL empty_after done=%b req_cycles=%0d want 0/0", done, req_cnt);
    end
  endtask

  task automatic test_three_cell();
    logic [15:0] exp_car [3] = '{16'hDEAD, 16'h1234, 16'hABCD};
    logic [11:0] exp_rd  [6] = '{12'h010, 12'h011, 12'h012, 12'h013, 12'h014, 12'h015};
    logic [15:0] gc;
    logic [11:0] gr;
    bit seen;
    cars.delete();
    reads.delete();
    car_ready = 1'b1;
    start_walk(16'h1010);
    wait_done(100, seen);
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL three_timeout done not seen within 100 cycles");
    end
    n_vec++;
    if (count !== 16'd3 || error !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL three_result count=%0d error=%b busy=%b want 3/0/0", count, error, busy);
    end
    for (int i = 0; i < 3; i++) begin
      gc = (i < cars.size()) ? cars[i] : 16'hxxxx;
      n_vec++;
      if (gc !== exp_car[i]) begin
        n_err++;
        $display("FAIL three_car[%0d] got=%h want=%h", i, gc, exp_car[i]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      gr = (i < reads.size()) ? reads[i] : 12'hxxx;
      n_vec++;
      if (gr !== exp_rd[i]) begin
        n_err++;
        $display("FAIL three_read[%0d] got=%h want=%h", i, gr, exp_rd[i]);
      end
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || count !== 16'd3 || cars.size() !== 3 || reads.size() !== 6) begin
      n_err++;
      $display("FAIL three_hold done=%b count=%0d cars=%0d reads=%0d want 0/3/3/6",
               done, count, cars.size(), reads.size());
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_car [3] = '{16'hDEAD, 16'h1234, 16'hABCD};
    logic [15:0] held;
    logic [15:0] gc;
    bit seen;
    int stall_bad;
    cars.delete();
    car_ready = 1'b0;
    stall_bad = 0;
    start_walk(16'h1010);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 50 && car_valid !== 1'b1; i++) @(negedge clk);
      held = car_data;
      repeat (5) begin
        @(negedge clk);
        if (car_valid !== 1'b1 || car_data !== held || req !== 1'b0) stall_bad++;
      end
      car_ready = 1'b1;
      @(negedge clk);
      car_ready = 1'b0;
    end
    wait_done(100, seen);
    n_vec++;
    if (!seen || stall_bad !== 0) begin
      n_err++;
      $display("FAIL bp_stall seen_done=%b bad_stall_cycles=%0d want 1/0", seen, stall_bad);
    end
    n_vec++;
    if (count !== 16'd3 || error !== 1'b0 || cars.size() !== 3) begin
      n_err++;
      $display("FAIL bp_result count=%0d error=%b cars=%0d want 3/0/3", count, error, cars.size());
    end
    for (int i = 0; i < 3; i++) begin
      gc = (i < cars.size()) ? cars[i] : 16'hxxxx;
      n_vec++;
      if (gc !== exp_car[i]) begin
        n_err++;
        $display("FAIL bp_car[%0d] got=%h want=%h", i, gc, exp_car[i]);
      end
    end
    car_ready = 1'b1;
  endtask

  task automatic test_improper();
    bit seen;
    cars.delete();
    car_ready = 1'b1;
    start_walk(16'h1020);
    wait_done(100, seen);
    n_vec++;
    if (!seen || count !== 16'd1 || error !== 1'b1) begin
      n_err++;
      $display("FAIL improper seen=%b count=%0d error=%b want 1/1/1", seen, count, error);
    end
    n_vec++;
    if (cars.size() !== 1 || (cars.size() > 0 && cars[0] !== 16'h0042)) begin
      n_err++;
      $display("FAIL improper_car n=%0d first=%h want 1/0042", cars.size(),
               cars.size() > 0 ? cars[0] : 16'hxxxx);
    end
  endtask

  task automatic test_atom_head();
    start_walk(16'h7005);
    n_vec++;
    if (done !== 1'b1 || error !== 1'b1 || count !== 16'd0) begin
      n_err++;
      $display("FAIL atom_head done=%b error=%b count=%0d want 1/1/0", done, error, count);
    end
  endtask

  task automatic test_cycle();
    bit seen;
    int bad;
    cars.delete();
    start_walk(16'h1030);
    wait_done(200, seen);
    n_vec++;
    if (!seen || count !== 16'd4 || error !== 1'b1) begin
      n_err++;
      $display("FAIL cycle seen=%b count=%0d error=%b want 1/4/1", seen, count, error);
    end
    bad = 0;
    foreach (cars[i]) if (cars[i] !== 16'h0001) bad++;
    n_vec++;
    if (cars.size() !== 4 || bad !== 0) begin
      n_err++;
      $display("FAIL cycle_cars n=%0d bad=%0d want 4/0", cars.size(), bad);
    end
  endtask

  task automatic test_wrap();
    bit seen;
    cars.delete();
    reads.delete();
    start_walk(16'h1FFF);
    wait_done(100, seen);
    n_vec++;
    if (!seen || count !== 16'd1 || error !== 1'b0) begin
      n_err++;
      $display("FAIL wrap seen=%b count=%0d error=%b want 1/1/0", seen, count, error);
    end
    n_vec++;
    if (reads.size() !== 2 || (reads.size() == 2 && (reads[0] !== 12'hFFF || reads[1] !== 12'h000))
        || cars.size() !== 1 || (cars.size() == 1 && cars[0] !== 16'hBEEF)) begin
      n_err++;
      $display("FAIL wrap_addr reads=%0d cars=%0d want FFF,000 / BEEF", reads.size(), cars.size());
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    bit found;
    found = 1'b0;
    car_ready = 1'b1;
    start_walk(16'h1010);
    for (int i = 0; i < 50; i++) begin
      if (req === 1'b1 && data_ready === 1'b0 && addr_in === 12'h011) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (!found || {busy, done, error, req, car_valid} !== 5'b0) begin
      n_err++;
      $display("FAIL midrst_flags found=%b flags=%b want 1/00000", found,
               {busy, done, error, req, car_valid});
    end
    n_vec++;
    if (addr_in !== 12'h000 || car_data !== 16'h0000 || count !== 16'd0) begin
      n_err++;
      $display("FAIL midrst_data addr=%h car=%h count=%0d want 000/0000/0", addr_in, car_data, count);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++;
    if (done_cnt !== d0 || busy !== 1'b0 || req !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_quiet done_pulses=%0d busy=%b req=%b want 0/0/0",
               done_cnt - d0, busy, req);
    end
    test_three_cell();
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 16'h0000;
    mem[12'h010] = 16'hDEAD; mem[12'h011] = 16'h1012;
    mem[12'h012] = 16'h1234; mem[12'h013] = 16'h1014;
    mem[12'h014] = 16'hABCD; mem[12'h015] = 16'h0000;
    mem[12'h020] = 16'h0042; mem[12'h021] = 16'h7005;
    mem[12'h030] = 16'h0001; mem[12'h031] = 16'h1030;
    mem[12'hFFF] = 16'hBEEF;

    test_reset();
    test_empty();
    test_three_cell();
    test_backpressure();
    test_improper();
    test_atom_head();
    test_cycle();
    test_wrap();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
